// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: owns the PC, issues one synchronous-read
// request per cycle and queues returned {pc, instruction} pairs for decode.
// A redirect or reset flushes the queue and drops any read still in flight.
module fetch_queue_unit #(
  parameter int               WIDTH   = 32,
  parameter int               DEPTH   = 4,
  parameter logic [WIDTH-1:0] INIT_PC = 32'h00400020,
  parameter int               PC_INC  = 4
) (
  input  logic                     i_clk,
  input  logic                     i_start_up_n,
  output logic                     o_imem_req,
  output logic [WIDTH-1:0]         o_imem_addr,
  input  logic [WIDTH-1:0]         i_imem_rdata,
  input  logic                     i_redirect,
  input  logic [WIDTH-1:0]         i_redirect_pc,
  output logic                     o_inst_valid,
  input  logic                     i_inst_ready,
  output logic [WIDTH-1:0]         o_inst_out,
  output logic [WIDTH-1:0]         o_inst_pc,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW+1:0] DEPTH_OCC = (AW+2)'(DEPTH);

  logic [WIDTH-1:0] r_pc;
  logic             r_fl;
  logic [WIDTH-1:0] r_fl_pc;
  logic [AW:0]      r_count;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [WIDTH-1:0] r_q_inst [DEPTH];
  logic [WIDTH-1:0] r_q_pc   [DEPTH];

  logic [AW+1:0]    w_occ;
  logic             w_pop;
  logic             w_push;
  logic             w_issue;

  // Occupancy includes the outstanding read so the queue can never overflow
  // when that read lands; a full queue may still issue if the head is popped.
  always_comb begin
    w_occ   = {1'b0, r_count} + (AW+2)'(r_fl);
    w_pop   = o_inst_valid & i_inst_ready;
    w_push  = r_fl & ~i_redirect;
    w_issue = i_start_up_n & ~i_redirect &
              ((w_occ < DEPTH_OCC) | ((w_occ == DEPTH_OCC) & w_pop));
  end

  // PC, in-flight tag, pointers and occupancy; reset beats redirect beats normal flow.
  always_ff @(posedge i_clk) begin
    if (!i_start_up_n) begin
      r_pc     <= INIT_PC;
      r_fl     <= 1'b0;
      r_fl_pc  <= '0;
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else if (i_redirect) begin
      r_pc     <= i_redirect_pc;
      r_fl     <= 1'b0;
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else begin
      r_fl <= w_issue;
      if (w_issue) begin
        r_pc    <= r_pc + WIDTH'(PC_INC);
        r_fl_pc <= r_pc;
      end
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Queue storage; contents need no reset because empty slots are masked on output.
  always_ff @(posedge i_clk) begin
    if (i_start_up_n && w_push) begin
      r_q_inst[r_wr_ptr] <= i_imem_rdata;
      r_q_pc[r_wr_ptr]   <= r_fl_pc;
    end
  end

  // Consumer-side outputs come from registered state only.
  always_comb begin
    o_inst_valid = (r_count != '0);
    o_inst_out   = o_inst_valid ? r_q_inst[r_rd_ptr] : '0;
    o_inst_pc    = o_inst_valid ? r_q_pc[r_rd_ptr]   : '0;
    o_count      = r_count;
    o_imem_req   = w_issue;
    o_imem_addr  = r_pc;
  end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: a stream-level scoreboard predicts the PCs the
// consumer must see (sequential from each reset/redirect target) and a
// monitor compares every pop; directed phases cover latency, back-pressure,
// redirect, reset and PC wrap, followed by a randomized phase.
module tb_fetch_queue_unit;

  localparam int          D    = 4;
  localparam logic [31:0] K    = 32'hA5A5A5A5;
  localparam logic [31:0] INIT = 32'h00400020;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0, redir = 1'b0, ready = 1'b0;
  logic [31:0] redir_pc = '0, rdata = '0;
  logic        req, valid;
  logic [31:0] addr, iout, ipc;
  logic [2:0]  cnt;

  logic        rst2_n = 1'b0;
  logic        ready2 = 1'b1, redir2 = 1'b0;
  logic [31:0] redir_pc2 = '0, rdata2 = '0;
  logic        req2, valid2;
  logic [31:0] addr2, iout2, ipc2;
  logic [2:0]  cnt2;

  fetch_queue_unit dut (
    .i_clk(clk), .i_start_up_n(rst_n), .o_imem_req(req), .o_imem_addr(addr),
    .i_imem_rdata(rdata), .i_redirect(redir), .i_redirect_pc(redir_pc),
    .o_inst_valid(valid), .i_inst_ready(ready), .o_inst_out(iout),
    .o_inst_pc(ipc), .o_count(cnt));

  fetch_queue_unit #(.INIT_PC(32'hFFFFFFF8)) dut_wrap (
    .i_clk(clk), .i_start_up_n(rst2_n), .o_imem_req(req2), .o_imem_addr(addr2),
    .i_imem_rdata(rdata2), .i_redirect(redir2), .i_redirect_pc(redir_pc2),
    .o_inst_valid(valid2), .i_inst_ready(ready2), .o_inst_out(iout2),
    .o_inst_pc(ipc2), .o_count(cnt2));

  // Synchronous-read memory: word at address a holds a ^ K; junk when idle.
  always @(posedge clk) begin
    rdata  <= req  ? (addr  ^ K) : $urandom;
    rdata2 <= req2 ? (addr2 ^ K) : $urandom;
  end

  int n_checks = 0, n_pass = 0, n_pops = 0, n_pops2 = 0;
  logic [31:0] exp_q[$];
  logic [31:0] restart_q[$];
  logic [31:0] exp2 = 32'hFFFFFFF8;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  // Each reset/redirect cycle issued by stimulus queues the start of the new stream.
  task automatic cyc(input logic rn, input logic rd, input logic [31:0] tgt, input logic rdy);
    @(posedge clk); #1;
    rst_n = rn; redir = rd; redir_pc = tgt; ready = rdy;
    if (!rn) restart_q.push_back(INIT);
    else if (rd) restart_q.push_back(tgt);
  endtask

  task automatic restart_stream();
    logic [31:0] s;
    n_checks++;
    if (restart_q.size() == 0) begin
      $display("FAIL restart_q actual=empty required=entry");
      return;
    end
    n_pass++;
    s = restart_q.pop_front();
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(s + 32'(4 * i));
  endtask

  // Monitor: compare every delivered instruction against the predicted stream.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      chk("count_bound", 32'(cnt <= 3'(D)), 1);
      if (!valid) begin
        chk("empty_out", iout, 0);
        chk("empty_pc", ipc, 0);
      end
      if (!rst_n) restart_stream();
      else begin
        if (valid && ready) begin
          n_pops++;
          if (exp_q.size() == 0) chk("pop_unexpected", ipc, 32'hDEADBEEF ^ ipc);
          else begin
            e = exp_q.pop_front();
            chk("pop_pc", ipc, e);
            chk("pop_inst", iout, e ^ K);
            while (exp_q.size() < 8) exp_q.push_back(exp_q[exp_q.size()-1] + 32'd4);
          end
        end
        if (redir) restart_stream();
      end
    end
  end

  // Monitor for the wrap instance: first six pops must walk across 2^32.
  initial begin
    forever begin
      @(negedge clk);
      if (rst2_n && valid2 && ready2 && n_pops2 < 6) begin
        chk("wrap_pc", ipc2, exp2);
        chk("wrap_inst", iout2, exp2 ^ K);
        exp2 = exp2 + 32'd4;
        n_pops2++;
      end
    end
  end

  task automatic wait_valid(input string name, input logic [31:0] exp_pc);
    bit got = 0;
    for (int i = 0; i < 6 && !got; i++) begin
      cyc(1, 0, 0, 1);
      @(negedge clk);
      if (valid) got = 1;
    end
    chk({name, "_valid"}, 32'(valid), 1);
    chk(name, ipc, exp_pc);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst2_n = 1'b1;
  end

  initial begin
    // Reset state
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    @(negedge clk);
    chk("rst_req", 32'(req), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_count", 32'(cnt), 0);
    chk("rst_addr", addr, INIT);

    // Free-running latency
    cyc(1, 0, 0, 1); @(negedge clk);
    chk("lat_req", 32'(req), 1);
    chk("lat_addr0", addr, INIT);
    chk("lat_valid0", 32'(valid), 0);
    cyc(1, 0, 0, 1); @(negedge clk);
    chk("lat_addr1", addr, INIT + 32'd4);
    chk("lat_valid1", 32'(valid), 0);
    cyc(1, 0, 0, 1); @(negedge clk);
    chk("lat_valid2", 32'(valid), 1);
    chk("lat_pc2", ipc, INIT);
    for (int i = 0; i < 10; i++) begin
      cyc(1, 0, 0, 1); @(negedge clk);
      chk("stream_count", 32'(cnt <= 3'd1), 1);
    end

    // Redirect with a read in flight and a pop at count 1
    cyc(1, 1, 32'h00400100, 1); @(negedge clk);
    chk("redir_cnt_before", 32'(cnt), 1);
    chk("redir_pop_valid", 32'(valid), 1);
    cyc(1, 0, 0, 1); @(negedge clk);
    chk("redir_cnt_after", 32'(cnt), 0);
    chk("redir_addr", addr, 32'h00400100);
    chk("redir_req", 32'(req), 1);
    wait_valid("redir_first_pc", 32'h00400100);
    repeat (4) cyc(1, 0, 0, 1);

    // Back-to-back redirects: last target wins
    cyc(1, 1, 32'h00400200, 1);
    cyc(1, 1, 32'h00400300, 1);
    wait_valid("redir2_first_pc", 32'h00400300);
    repeat (4) cyc(1, 0, 0, 1);

    // Back-pressure fills the queue
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    repeat (8) cyc(1, 0, 0, 0);
    @(negedge clk);
    chk("full_count", 32'(cnt), D);
    chk("full_req", 32'(req), 0);
    cyc(1, 0, 0, 1); @(negedge clk);
    chk("resume_req", 32'(req), 1);
    chk("resume_pc", ipc, INIT);
    repeat (8) cyc(1, 0, 0, 1);

    // Reset while count=3 with a read in flight
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    repeat (4) cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0); @(negedge clk);
    chk("midrst_cnt_before", 32'(cnt), 3);
    cyc(1, 0, 0, 0); @(negedge clk);
    chk("midrst_cnt", 32'(cnt), 0);
    chk("midrst_valid", 32'(valid), 0);
    chk("midrst_addr", addr, INIT);
    repeat (8) cyc(1, 0, 0, 1);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      logic rn, rd, rdy;
      rn  = ($urandom_range(0, 99) != 0);
      rd  = rn && ($urandom_range(0, 19) == 0);
      rdy = ($urandom_range(0, 9) < 7);
      cyc(rn, rd, $urandom & 32'hFFFFFFFC, rdy);
    end
    repeat (10) cyc(1, 0, 0, 1);
    @(negedge clk);
    chk("pop_total", 32'(n_pops >= 200), 1);
    chk("wrap_pops", 32'(n_pops2), 6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
- Parametrised instruction-fetch front end for the next-generation processor. Replaces the bare PC register and next-PC path of the single-cycle datapath.
- Holds the PC, drives a synchronous-read instruction memory, and buffers fetched {pc, instruction} pairs in a DEPTH-entry FIFO. The decode stage consumes entries through a valid/ready handshake.
- Supports back-pressure stalls and branch/jump redirects. A redirect flushes the queue and discards any in-flight read.

Parameters:
WIDTH, 32, width of PC, addresses and instruction words
DEPTH, 4, queue entries (power of two, >= 2)
INIT_PC, 32'h00400020, PC value loaded on reset
PC_INC, 4, PC increment per sequential fetch

Ports:
clk  in  1  clock, all state updates on rising edge
start_up_n  in  1  synchronous active-low reset; low at a rising edge resets all state
imem_req  out  1  instruction memory read strobe
imem_addr  out  WIDTH  read address (current PC)
imem_rdata  in  WIDTH  read data, valid exactly one cycle after imem_req
redirect  in  1  branch/jump taken this cycle
redirect_pc  in  WIDTH  target PC when redirect=1
inst_valid  out  1  queue head valid
inst_ready  in  1  consumer accepts head
inst_out  out  WIDTH  head instruction (0 when empty)
inst_pc  out  WIDTH  PC of head instruction (0 when empty)
count  out  log2(DEPTH)+1  entries currently queued

Behaviour:
- Reset (start_up_n=0 at an edge):
  - pc<=INIT_PC; count<=0; in-flight flag<=0; inst_valid=0; imem_req=0.
  - inst_out=0 and inst_pc=0.
- Reset overrides everything. Asserted mid-operation, it drops the queue and the in-flight read; the response arriving the next cycle is ignored.
- Naming: pop = inst_valid & inst_ready. Occupancy = count + in-flight (0 or 1).
- Issue rule: imem_req=1 when start_up_n=1, redirect=0, and (occupancy<DEPTH, or occupancy==DEPTH with pop). imem_req is combinational on inst_ready and redirect.
- Issue cycle:
  - imem_addr=pc.
  - At the edge: pc<=pc+PC_INC, modulo 2^WIDTH (0xFFFFFFFC wraps to 0x00000000); in-flight tag <= {1, pc}.
- Response: the cycle after an issue, imem_rdata is written into the tail with its tagged PC, unless a redirect occurs that cycle. Only one read is outstanding per cycle, but issue may repeat every cycle, so throughput is 1 instruction/cycle.
- Latency: first imem_req in the first cycle after reset release. inst_valid rises two edges later. Response is never bypassed to the head.
- Simultaneous pop and push: count unchanged. The queue never overflows, by the issue rule.
- Redirect=1:
  - No issue that cycle.
  - At the edge: pc<=redirect_pc; count<=0; in-flight response discarded; read/write pointers reset.
  - A pop in the redirect cycle still counts as delivered to the consumer.
  - First fetch of redirect_pc occurs the next cycle.
- Redirect on consecutive cycles: the last one wins.
- Empty queue: inst_valid=0; inst_out and inst_pc forced to 0; inst_ready ignored.
- Outputs inst_valid, inst_out, inst_pc and count derive from registered state only. No combinational path from inst_ready or redirect to them.

Test Plan:
1. Reset, then release with inst_ready=1 and imem returning addr^32'hA5A5A5A5 -> imem_addr sequence 0x00400020, 0x00400024, ...; inst_valid first high 2 edges after release; then one pop per cycle with inst_pc matching, count<=1.
2. inst_ready=0 from release -> count climbs to 4 (DEPTH); imem_req low once occupancy=4. Raise ready -> entries 0x00400020..0x0040002C pop in order; fetch resumes the same cycle as the first pop.
3. Streaming, then redirect=1 with redirect_pc=0x00400100 while a read is in flight -> count=0 next cycle; stale response never appears; next inst_pc popped is 0x00400100; no PC between the old stream and 0x00400100 is delivered.
4. INIT_PC=32'hFFFFFFF8 override, free-running -> fetched PCs 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, 0x00000004.
5. start_up_n driven low for one edge while count=3 with a read in flight -> next cycle count=0, inst_valid=0, imem_addr=INIT_PC; the late imem_rdata is never enqueued.
6. Redirect in the same cycle as a pop at count=1 -> popped entry is delivered once; count=0 after the edge; no duplicate entry.
